led_override: RTL

- Downstream consumer of the LED bouncer pattern. Drives the board LED pins.
- Selects between the free-running bouncer pattern (i_bounce) and a software-written LED value. Software writes over a Wishbone (pipelined) slave port.
- A software write takes over the LEDs for a programmable number of clocks, then control returns to the bouncer automatically. Software may also force or release control explicitly.

---
 rtl/led_override.sv | 139 +++++++++++++
 1 files changed

// File: rtl/led_override.sv
// LED output selector: passes the bouncer pattern through, or shows a software-written
// value held for a programmable number of clocks (HOLD) or until explicitly released (FORCE).
module led_override #(
  parameter int          NLEDS        = 8,
  parameter logic [31:0] DEFAULT_HOLD = 32'd100_000_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic             i_wb_addr,
  input  logic [31:0]      i_wb_data,
  input  logic [3:0]       i_wb_sel,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic [31:0]      o_wb_data,
  input  logic [NLEDS-1:0] i_bounce,
  output logic [NLEDS-1:0] o_leds,
  output logic             o_int
);

  // Handshake: a request is any clock with i_wb_stb && i_wb_cyc; it is never stalled
  // and is acknowledged exactly one clock later, with read data valid alongside the ack.

  typedef enum logic [1:0] {
    ST_AUTO  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [NLEDS-1:0] sw_leds, sw_leds_next, mask, leds_next;
  logic [31:0]      counter, counter_next, timeout, timeout_next;
  logic             int_next;
  logic             bus_req, ctrl_wr, tmo_wr, rel_req, frc_req;
  logic [7:0]       leds8, sw8;
  logic [31:0]      rdata;

  assign o_wb_stall = 1'b0;

  always_comb begin
    bus_req = i_wb_stb && i_wb_cyc;
    ctrl_wr = bus_req && i_wb_we && !i_wb_addr;
    tmo_wr  = bus_req && i_wb_we && i_wb_addr;
    mask    = i_wb_sel[1] ? i_wb_data[8 +: NLEDS] : '0;
    rel_req = i_wb_sel[3] && i_wb_data[30];
    frc_req = i_wb_sel[3] && i_wb_data[31];
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    sw_leds_next = sw_leds;
    timeout_next = timeout;
    int_next     = 1'b0;

    case (state)
      ST_HOLD: begin
        // A zero count means HOLD was entered with timeout==0 and never expires.
        if (counter == 32'd1) begin
          state_next   = ST_AUTO;
          counter_next = '0;
          int_next     = 1'b1;
        end else if (counter != '0) begin
          counter_next = counter - 32'd1;
        end
      end
      default: counter_next = '0;
    endcase

    if (tmo_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wb_sel[b]) timeout_next[8*b +: 8] = i_wb_data[8*b +: 8];
      end
    end

    // A CTRL write overrides the expiry decided above, so a reload on the last HOLD clock wins.
    if (ctrl_wr) begin
      if (i_wb_sel[0]) begin
        if (mask == '0) sw_leds_next = i_wb_data[NLEDS-1:0];
        else            sw_leds_next = (sw_leds & ~mask) | (i_wb_data[NLEDS-1:0] & mask);
      end
      if (rel_req) begin
        state_next   = ST_AUTO;
        counter_next = '0;
        int_next     = 1'b0;
      end else if (frc_req) begin
        state_next   = ST_FORCE;
        counter_next = '0;
        int_next     = 1'b0;
      end else if (i_wb_sel[0]) begin
        state_next   = ST_HOLD;
        counter_next = timeout;
        int_next     = 1'b0;
      end
    end

    leds_next = (state_next == ST_AUTO) ? i_bounce : sw_leds_next;
  end

  always_comb begin
    leds8              = '0;
    sw8                = '0;
    leds8[NLEDS-1:0]   = o_leds;
    sw8[NLEDS-1:0]     = sw_leds;
    if (i_wb_addr) rdata = timeout;
    else           rdata = {state == ST_FORCE, state == ST_HOLD, 6'b0, leds8, 8'b0, sw8};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= ST_AUTO;
      sw_leds <= '0;
      counter <= '0;
      timeout <= DEFAULT_HOLD;
      o_leds  <= '0;
      o_int   <= 1'b0;
    end else begin
      state   <= state_next;
      sw_leds <= sw_leds_next;
      counter <= counter_next;
      timeout <= timeout_next;
      o_leds  <= leds_next;
      o_int   <= int_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc) o_wb_ack <= 1'b0;
    else                      o_wb_ack <= i_wb_stb;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)      o_wb_data <= '0;
    else if (bus_req) o_wb_data <= rdata;
  end

endmodule
